alu_issue_unit: RTL and testbench

- Upstream control stage for the 4-bit, 3-bit-opcode combinational ALU.
- Holds a 4-entry x 4-bit register file and accepts 9-bit register-register instructions over a valid/ready handshake.
- Drives the ALU's operand and opcode inputs from registered values, captures the ALU result, writes it back to the destination register, and reports the result with a one-cycle valid pulse.

---
 rtl/alu_issue_unit_pkg.sv | 51 +++++
 rtl/alu_issue_unit_if.sv | 34 +++
 rtl/alu.sv | 29 ++
 rtl/alu_regfile.sv | 45 ++++
 rtl/alu_issue_unit.sv | 112 +++++++++++
 tb/tb_alu_issue_unit.sv | 233 +++++++++++++++++++++++
 6 files changed

// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: widths, opcodes, FSM states, instruction fields.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_issue_unit_pkg;

  localparam int DATA_W  = 4;
  localparam int NREGS   = 4;
  localparam int RADDR_W = 2;
  localparam int OPC_W   = 3;
  localparam int INSTR_W = OPC_W + 3 * RADDR_W;

  // Instruction layout: {opcode, rd, rs1, rs2}
  localparam int OPC_LSB = 6;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 2;
  localparam int RS2_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_ZERO  = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_NOT1  = 3'b101,
    OP_NOT2  = 3'b110,
    OP_ZERO2 = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: RADDR_W];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
    return instr[RS1_LSB +: RADDR_W];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
    return instr[RS2_LSB +: RADDR_W];
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Bundle of instruction handshake, register load port, ALU drive/return and result report.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates in_valid; all other groups are unthrottled.
// master = instruction source / ALU side, slave = the issue unit.
interface alu_issue_unit_if;
  import alu_issue_unit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic                 ld_en;
  logic [RADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]    ld_data;
  logic [DATA_W-1:0]    alu_opperand_1;
  logic [DATA_W-1:0]    alu_opperand_2;
  logic [OPC_W-1:0]     alu_opcode;
  logic [DATA_W-1:0]    alu_result;
  logic                 result_valid;
  logic [DATA_W-1:0]    result;
  logic [RADDR_W-1:0]   result_rd;
  logic                 result_zero;

  modport slave (
    input  in_valid, in_instr, ld_en, ld_addr, ld_data, alu_result,
    output in_ready, alu_opperand_1, alu_opperand_2, alu_opcode,
           result_valid, result, result_rd, result_zero
  );

  modport master (
    output in_valid, in_instr, ld_en, ld_addr, ld_data, alu_result,
    input  in_ready, alu_opperand_1, alu_opperand_2, alu_opcode,
           result_valid, result, result_rd, result_zero
  );
endinterface

// File: rtl/alu.sv
// 4-bit, 3-bit-opcode combinational ALU driven by the issue unit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: opperand_1/opperand_2/opcode in, result out; all arithmetic wraps mod 2^DATA_W.
module alu
  import alu_issue_unit_pkg::*;
(
  input  logic [DATA_W-1:0] opperand_1,
  input  logic [DATA_W-1:0] opperand_2,
  input  logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ZERO:  result = '0;
      OP_ADD:   result = opperand_1 + opperand_2;
      OP_SUB:   result = opperand_1 - opperand_2;
      OP_AND:   result = opperand_1 & opperand_2;
      OP_OR:    result = opperand_1 | opperand_2;
      OP_NOT1:  result = ~opperand_1;
      OP_NOT2:  result = ~opperand_2;
      OP_ZERO2: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, load and writeback write ports.
// Latency: reads 0 cycles, writes visible the cycle after the edge.
// Backpressure: none; writeback overrides a same-address load in the same cycle.
// Ports: clk/rst, raddr1/raddr2 -> rdata1/rdata2, ld_en/ld_addr/ld_data, wb_en/wb_addr/wb_data.
module alu_regfile #(
  parameter int DATA_W  = 4,
  parameter int NREGS   = 4,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2,
  input  logic               ld_en,
  input  logic [RADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data
);

  logic [DATA_W-1:0] mem [NREGS];

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        mem[ld_addr] <= ld_data;
      end
      // Issued after the load so the writeback is the surviving value on an address clash.
      if (wb_en) begin
        mem[wb_addr] <= wb_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the combinational ALU: decode, operand fetch with load bypass, writeback, report.
// Latency: 3 cycles per instruction (IDLE accept -> EXEC -> WB pulse), no overlap.
// Backpressure: in_ready is high only in IDLE; ld_en is taken every cycle.
// Ports: clk, rst (sync, active high), bus (slave modport: handshake, load port, ALU drive/return, result).
module alu_issue_unit
  import alu_issue_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_issue_unit_if.slave    bus
);

  state_e              state;
  logic [RADDR_W-1:0]  rd_q;
  logic [DATA_W-1:0]   opnd1_q;
  logic [DATA_W-1:0]   opnd2_q;
  logic [OPC_W-1:0]    opcode_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_q;
  logic [RADDR_W-1:0]  res_rd_q;
  logic                res_zero_q;

  logic [RADDR_W-1:0]  rs1;
  logic [RADDR_W-1:0]  rs2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic [DATA_W-1:0]   opnd1_nxt;
  logic [DATA_W-1:0]   opnd2_nxt;
  logic                accept;
  logic                wb_en;

  assign rs1    = instr_rs1(bus.in_instr);
  assign rs2    = instr_rs2(bus.in_instr);
  assign accept = bus.in_valid && (state == IDLE);
  // NOP traverses the pipe but must leave the register file untouched.
  assign wb_en  = (state == EXEC) && (opcode_q != OP_ZERO);

  // A load landing in the accept cycle is forwarded so the operand is never stale.
  assign opnd1_nxt = (bus.ld_en && (bus.ld_addr == rs1)) ? bus.ld_data : rdata1;
  assign opnd2_nxt = (bus.ld_en && (bus.ld_addr == rs2)) ? bus.ld_data : rdata2;

  alu_regfile #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .RADDR_W (RADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr1  (rs1),
    .raddr2  (rs2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .ld_en   (bus.ld_en),
    .ld_addr (bus.ld_addr),
    .ld_data (bus.ld_data),
    .wb_en   (wb_en),
    .wb_addr (rd_q),
    .wb_data (bus.alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      opnd1_q     <= '0;
      opnd2_q     <= '0;
      opcode_q    <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_rd_q    <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (accept) begin
            opcode_q <= instr_opcode(bus.in_instr);
            rd_q     <= instr_rd(bus.in_instr);
            opnd1_q  <= opnd1_nxt;
            opnd2_q  <= opnd2_nxt;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= bus.alu_result;
          res_rd_q    <= rd_q;
          res_zero_q  <= (bus.alu_result == '0);
          res_valid_q <= 1'b1;
          state       <= WB;
        end
        WB: begin
          res_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          res_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready       = (state == IDLE);
  assign bus.alu_opperand_1 = opnd1_q;
  assign bus.alu_opperand_2 = opnd2_q;
  assign bus.alu_opcode     = opcode_q;
  assign bus.result_valid   = res_valid_q;
  assign bus.result         = res_q;
  assign bus.result_rd      = res_rd_q;
  assign bus.result_zero    = res_zero_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with the ALU attached: reference model compared every cycle plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_unit_if bus ();

  alu u_alu (
    .opperand_1 (bus.alu_opperand_1),
    .opperand_2 (bus.alu_opperand_2),
    .opcode     (bus.alu_opcode),
    .result     (bus.alu_result)
  );

  alu_issue_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return ~a;
      3'd6:    return ~b;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] s1, input logic [1:0] s2);
    return {op, rd, s1, s2};
  endfunction

  // Reference model: an instruction is "in flight" for two cycles after it is accepted.
  logic [3:0] m_reg [4];
  int         m_busy;
  logic [3:0] m_a, m_b, m_res, t_res;
  logic [2:0] m_op;
  logic [1:0] m_rd, m_res_rd;
  logic       m_valid, m_zero, t_wb;
  bit         m_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
      m_busy = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
      m_res = 0; m_res_rd = 0; m_valid = 0; m_zero = 0;
      m_live = 1;
    end else begin
      t_wb    = 1'b0;
      m_valid = 1'b0;
      if (m_busy == 2) begin
        t_res    = ref_alu(m_op, m_a, m_b);
        m_res    = t_res;
        m_res_rd = m_rd;
        m_zero   = (t_res == 4'd0);
        m_valid  = 1'b1;
        t_wb     = (m_op != 3'd0);
        m_busy   = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
      end else if (bus.in_valid) begin
        m_op = bus.in_instr[8:6];
        m_rd = bus.in_instr[5:4];
        m_a  = (bus.ld_en && bus.ld_addr == bus.in_instr[3:2]) ? bus.ld_data : m_reg[bus.in_instr[3:2]];
        m_b  = (bus.ld_en && bus.ld_addr == bus.in_instr[1:0]) ? bus.ld_data : m_reg[bus.in_instr[1:0]];
        m_busy = 2;
      end
      if (bus.ld_en) m_reg[bus.ld_addr] = bus.ld_data;
      if (t_wb) m_reg[m_rd] = t_res;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mdl_in_ready", 8'(bus.in_ready), 8'(m_busy == 0));
      check("mdl_valid", 8'(bus.result_valid), 8'(m_valid));
      check("mdl_result", 8'(bus.result), 8'(m_res));
      check("mdl_result_rd", 8'(bus.result_rd), 8'(m_res_rd));
      check("mdl_opnd1", 8'(bus.alu_opperand_1), 8'(m_a));
      check("mdl_opnd2", 8'(bus.alu_opperand_2), 8'(m_b));
      check("mdl_opcode", 8'(bus.alu_opcode), 8'(m_op));
      if (m_valid) check("mdl_zero", 8'(bus.result_zero), 8'(m_zero));
    end
  end

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // Issue from IDLE; optional load in the accept cycle and in the EXEC cycle.
  task automatic issue(input string name, input logic [8:0] ins, input logic [3:0] exp_res,
                       input logic exp_zero,
                       input bit byp, input logic [1:0] byp_a, input logic [3:0] byp_d,
                       input bit exl, input logic [1:0] exl_a, input logic [3:0] exl_d);
    logic [1:0] exp_rd;
    bit seen;
    exp_rd = ins[5:4];
    check({name, "_ready"}, 8'(bus.in_ready), 8'd1);
    bus.in_valid = 1'b1; bus.in_instr = ins;
    bus.ld_en = byp; bus.ld_addr = byp_a; bus.ld_data = byp_d;
    @(negedge clk);
    // Busy: junk held on the bus must be ignored.
    bus.in_instr = 9'h1FF;
    bus.ld_en = exl; bus.ld_addr = exl_a; bus.ld_data = exl_d;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.ld_en = 1'b0;
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (bus.result_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check({name, "_seen"}, 8'(seen), 8'd1);
    if (seen) begin
      check({name, "_res"}, 8'(bus.result), 8'(exp_res));
      check({name, "_zero"}, 8'(bus.result_zero), 8'(exp_zero));
      check({name, "_rd"}, 8'(bus.result_rd), 8'(exp_rd));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [8:0] prog [3];
  logic [3:0] bexp [3];
  int nres;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 8'(bus.in_ready), 8'd1);
    check("rst_valid", 8'(bus.result_valid), 8'd0);
    check("rst_result", 8'(bus.result), 8'd0);
    check("rst_zero", 8'(bus.result_zero), 8'd0);
    check("rst_opcode", 8'(bus.alu_opcode), 8'd0);

    // Basic ADD and readback of the destination.
    load(2'd1, 4'd3); load(2'd2, 4'd5);
    issue("add", mk(OP_ADD, 0, 1, 2), 4'd8, 1'b0, 0, 0, 0, 0, 0, 0);
    issue("rd_r0", mk(OP_OR, 3, 0, 0), 4'd8, 1'b0, 0, 0, 0, 0, 0, 0);

    // SUB wraps; AND uses the fresh result.
    load(2'd1, 4'd2); load(2'd2, 4'd3);
    issue("sub", mk(OP_SUB, 3, 1, 2), 4'hF, 1'b0, 0, 0, 0, 0, 0, 0);
    issue("and", mk(OP_AND, 0, 3, 1), 4'd2, 1'b0, 0, 0, 0, 0, 0, 0);

    // NOP reports zero and leaves r2 alone.
    load(2'd2, 4'd5);
    issue("nop", mk(OP_ZERO, 2, 1, 2), 4'd0, 1'b1, 0, 0, 0, 0, 0, 0);
    issue("nop_chk", mk(OP_ADD, 3, 2, 2), 4'hA, 1'b0, 0, 0, 0, 0, 0, 0);

    // Bypass on rs1==rs2; same-address load during EXEC loses to writeback.
    issue("byp", mk(OP_OR, 0, 1, 1), 4'd9, 1'b0, 1, 2'd1, 4'd9, 1, 2'd0, 4'd7);
    issue("wbwin", mk(OP_OR, 3, 0, 0), 4'd9, 1'b0, 0, 0, 0, 0, 0, 0);
    // Different-address load during EXEC: both writes land; 9+9 wraps to 2.
    issue("wrap", mk(OP_ADD, 0, 1, 1), 4'd2, 1'b0, 0, 0, 0, 1, 2'd2, 4'd4);
    issue("both", mk(OP_ADD, 3, 0, 2), 4'd6, 1'b0, 0, 0, 0, 0, 0, 0);

    // Back-to-back with in_valid held: r0=2 r1=9 r2=4 r3=6.
    prog[0] = mk(OP_SUB, 1, 3, 2);  bexp[0] = 4'd2;
    prog[1] = mk(OP_NOT1, 2, 0, 0); bexp[1] = 4'hD;
    prog[2] = mk(OP_OR, 3, 1, 2);   bexp[2] = 4'hF;
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.result_valid === 1'b1) begin
        if (nres < 3) check("b2b_res", 8'(bus.result), 8'(bexp[nres]));
        nres++;
      end
      if (i >= 7) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_instr = (i % 3 == 1) ? mk(OP_ADD, 0, 3, 3) : prog[(i + 1) / 3];
      end
      @(negedge clk);
    end
    check("b2b_count", 8'(nres), 8'd3);

    // Opcode 111 writes zero.
    issue("zero2", mk(OP_ZERO2, 1, 3, 3), 4'd0, 1'b1, 0, 0, 0, 0, 0, 0);
    issue("zero2_chk", mk(OP_ADD, 0, 1, 3), 4'hF, 1'b0, 0, 0, 0, 0, 0, 0);

    // Reset during EXEC aborts the instruction and clears the register file.
    bus.in_valid = 1'b1; bus.in_instr = mk(OP_ADD, 0, 3, 3);
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 8'(bus.in_ready), 8'd1);
    for (int i = 0; i < 3; i++) begin
      check("abort_novalid", 8'(bus.result_valid), 8'd0);
      @(negedge clk);
    end
    issue("clr_a", mk(OP_OR, 2, 0, 3), 4'd0, 1'b1, 0, 0, 0, 0, 0, 0);
    issue("clr_b", mk(OP_ADD, 1, 2, 3), 4'd0, 1'b1, 0, 0, 0, 0, 0, 0);
    // rs2-only bypass after clear.
    issue("byp2", mk(OP_ADD, 0, 1, 2), 4'd6, 1'b0, 1, 2'd2, 4'd6, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
